// File: rtl/zilla_pc_ctrl_sched.sv
// PC-control scheduler: sequences boot, fetch, trap entry/exit and debug halt/resume.
// Optional single-step support is enabled by defining ZILLA_PC_CTRL_DBG_STEP_EN.
module zilla_pc_ctrl_sched #(
  parameter int BOOT_CYCLES = 4,
  parameter int INT_HOLDOFF = 2,
  parameter int ID_WIDTH    = 8
) (
  input  logic                z_clk,
  input  logic                z_rst,
  input  logic                wdt_reset_i,
  input  logic                dbg_hartreset_i,
  input  logic                stall_valid_i,
  input  logic                exception_valid_i,
  input  logic                interrupt_req_i,
  input  logic [ID_WIDTH-1:0] interrupt_id_i,
  input  logic                csr_mstatus_mie_i,
  input  logic                mret_valid_i,
  input  logic                dbg_haltreq_i,
  input  logic                dbg_resumereq_i,
`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
  input  logic                dbg_step_i,
`endif
  output logic [2:0]          zpc_pc_ctrl_o,
  output logic                trap_valid_o,
  output logic                ack_valid_o,
  output logic [ID_WIDTH-1:0] ack_interrupt_id_o,
  output logic                debug_mode_valid_o,
  output logic                resumeack_o
);

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int HW = $clog2(INT_HOLDOFF + 2);

  typedef enum logic [2:0] {
    RST_S    = 3'd0,
    RUN_S    = 3'd1,
    TRAP_S   = 3'd2,
    XRET_S   = 3'd3,
    HALT_S   = 3'd4,
    RESUME_S = 3'd5,
    STEP_S   = 3'd6
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_take_int;
  logic                w_rst;
  logic [BW-1:0]       r_boot_cnt;
  logic [HW-1:0]       r_hold;
  logic [2:0]          r_code;
  logic                r_trap;
  logic                r_ack;
  logic                r_dbg;
  logic                r_resack;
  logic [ID_WIDTH-1:0] r_ack_id;

  assign w_rst = z_rst | wdt_reset_i | dbg_hartreset_i;

  function automatic logic [2:0] code_of(input state_t s);
    case (s)
      RUN_S, STEP_S: code_of = 3'b001;
      TRAP_S:        code_of = 3'b010;
      XRET_S:        code_of = 3'b011;
      HALT_S:        code_of = 3'b100;
      RESUME_S:      code_of = 3'b101;
      default:       code_of = 3'b000;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    w_take_int = 1'b0;
    case (r_state)
      RST_S: if (r_boot_cnt == BW'(BOOT_CYCLES - 1)) w_next = RUN_S;
      RUN_S: begin
        if (dbg_haltreq_i) begin
          w_next = HALT_S;
        end else if (exception_valid_i) begin
          w_next = TRAP_S;
        end else if (interrupt_req_i && csr_mstatus_mie_i && !stall_valid_i && r_hold == '0) begin
          w_next     = TRAP_S;
          w_take_int = 1'b1;
        end else if (mret_valid_i && !stall_valid_i) begin
          w_next = XRET_S;
        end
      end
      TRAP_S, XRET_S: w_next = RUN_S;
      HALT_S: if (dbg_resumereq_i && !dbg_haltreq_i) w_next = RESUME_S;
`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
      RESUME_S: w_next = dbg_step_i ? STEP_S : RUN_S;
      STEP_S:   w_next = HALT_S;
`else
      RESUME_S: w_next = RUN_S;
`endif
      default: w_next = RST_S;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge z_clk) begin
    if (w_rst) begin
      r_state    <= RST_S;
      r_boot_cnt <= '0;
      r_hold     <= '0;
      r_code     <= 3'b000;
      r_trap     <= 1'b0;
      r_ack      <= 1'b0;
      r_dbg      <= 1'b0;
      r_resack   <= 1'b0;
      r_ack_id   <= '0;
    end else begin
      r_state    <= w_next;
      r_boot_cnt <= (r_state == RST_S && w_next == RST_S) ? r_boot_cnt + BW'(1) : '0;
      if (r_state == TRAP_S) r_hold <= HW'(INT_HOLDOFF);
      else if (r_hold != '0) r_hold <= r_hold - HW'(1);
      r_code   <= code_of(w_next);
      r_trap   <= (w_next == TRAP_S);
      r_ack    <= w_take_int;
      r_dbg    <= (w_next == HALT_S);
      r_resack <= (w_next == RESUME_S);
      if (w_take_int) r_ack_id <= interrupt_id_i;
    end
  end

  assign zpc_pc_ctrl_o      = r_code;
  assign trap_valid_o       = r_trap;
  assign ack_valid_o        = r_ack;
  assign ack_interrupt_id_o = r_ack_id;
  assign debug_mode_valid_o = r_dbg;
  assign resumeack_o        = r_resack;

endmodule

// File: tb/tb_zilla_pc_ctrl_sched.sv
// Directed self-checking bench for zilla_pc_ctrl_sched (BOOT_CYCLES=4, INT_HOLDOFF=2).
// Step tests run only when ZILLA_PC_CTRL_DBG_STEP_EN is defined.
module tb_zilla_pc_ctrl_sched;

  logic       z_clk = 1'b0;
  logic       z_rst, wdt_reset_i, dbg_hartreset_i, stall_valid_i, exception_valid_i;
  logic       interrupt_req_i, csr_mstatus_mie_i, mret_valid_i, dbg_haltreq_i, dbg_resumereq_i;
  logic [7:0] interrupt_id_i;
`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
  logic       dbg_step_i;
`endif
  logic [2:0] zpc_pc_ctrl_o;
  logic       trap_valid_o, ack_valid_o, debug_mode_valid_o, resumeack_o;
  logic [7:0] ack_interrupt_id_o;

  int total = 0;
  int bad   = 0;

  zilla_pc_ctrl_sched #(.BOOT_CYCLES(4), .INT_HOLDOFF(2), .ID_WIDTH(8)) dut (
    .z_clk              (z_clk),
    .z_rst              (z_rst),
    .wdt_reset_i        (wdt_reset_i),
    .dbg_hartreset_i    (dbg_hartreset_i),
    .stall_valid_i      (stall_valid_i),
    .exception_valid_i  (exception_valid_i),
    .interrupt_req_i    (interrupt_req_i),
    .interrupt_id_i     (interrupt_id_i),
    .csr_mstatus_mie_i  (csr_mstatus_mie_i),
    .mret_valid_i       (mret_valid_i),
    .dbg_haltreq_i      (dbg_haltreq_i),
    .dbg_resumereq_i    (dbg_resumereq_i),
`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
    .dbg_step_i         (dbg_step_i),
`endif
    .zpc_pc_ctrl_o      (zpc_pc_ctrl_o),
    .trap_valid_o       (trap_valid_o),
    .ack_valid_o        (ack_valid_o),
    .ack_interrupt_id_o (ack_interrupt_id_o),
    .debug_mode_valid_o (debug_mode_valid_o),
    .resumeack_o        (resumeack_o)
  );

  always #5 z_clk = ~z_clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge z_clk);
    #1;
  endtask

  task automatic test_reset();
    z_rst = 1'b1;
    step();
    step();
    total++;
    if ({zpc_pc_ctrl_o, trap_valid_o, ack_valid_o, debug_mode_valid_o, resumeack_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_state got code=%b pulses=%b%b%b%b want code=000 pulses=0000", zpc_pc_ctrl_o,
               trap_valid_o, ack_valid_o, debug_mode_valid_o, resumeack_o);
    end
    total++;
    if (ack_interrupt_id_o !== 8'h00) begin
      bad++;
      $display("FAIL reset_ack_id got=%h want=00", ack_interrupt_id_o);
    end
    z_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({zpc_pc_ctrl_o, trap_valid_o, ack_valid_o, debug_mode_valid_o, resumeack_o} !== 7'b0) begin
        bad++;
        $display("FAIL boot_hold[%0d] got code=%b pulses=%b%b%b%b want code=000 pulses=0000", i, zpc_pc_ctrl_o,
                 trap_valid_o, ack_valid_o, debug_mode_valid_o, resumeack_o);
      end
    end
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b001) begin
      bad++;
      $display("FAIL boot_to_run got=%b want=001", zpc_pc_ctrl_o);
    end
  endtask

  // Waits for the next trap pulse; returns cycles elapsed, or -1 if none within the budget.
  task automatic wait_trap(output int gap);
    gap = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (trap_valid_o === 1'b1) begin
        gap = k;
        break;
      end
    end
  endtask

  task automatic test_interrupt();
    int gap;
    interrupt_req_i   = 1'b1;
    interrupt_id_i    = 8'h0B;
    csr_mstatus_mie_i = 1'b1;
    step();
    total++;
    if ({zpc_pc_ctrl_o, trap_valid_o, ack_valid_o} !== 5'b010_1_1 || ack_interrupt_id_o !== 8'h0B) begin
      bad++;
      $display("FAIL int_take got code=%b trap=%b ack=%b id=%h want code=010 trap=1 ack=1 id=0b",
               zpc_pc_ctrl_o, trap_valid_o, ack_valid_o, ack_interrupt_id_o);
    end
    wait_trap(gap);
    total++;
    if (gap != 4) begin
      bad++;
      $display("FAIL int_holdoff_gap got=%0d want=4", gap);
    end
    interrupt_req_i = 1'b0;
    step();
    total++;
    if ({zpc_pc_ctrl_o, trap_valid_o, ack_valid_o} !== 5'b001_0_0) begin
      bad++;
      $display("FAIL trap_one_cycle got code=%b trap=%b ack=%b want code=001 trap=0 ack=0",
               zpc_pc_ctrl_o, trap_valid_o, ack_valid_o);
    end
    step();
    step();
  endtask

  task automatic test_exc_vs_int();
    int gap;
    exception_valid_i = 1'b1;
    interrupt_req_i   = 1'b1;
    interrupt_id_i    = 8'h22;
    step();
    total++;
    if ({zpc_pc_ctrl_o, trap_valid_o, ack_valid_o} !== 5'b010_1_0) begin
      bad++;
      $display("FAIL exc_wins got code=%b trap=%b ack=%b want code=010 trap=1 ack=0",
               zpc_pc_ctrl_o, trap_valid_o, ack_valid_o);
    end
    exception_valid_i = 1'b0;
    wait_trap(gap);
    total++;
    if (gap != 4 || ack_valid_o !== 1'b1 || ack_interrupt_id_o !== 8'h22) begin
      bad++;
      $display("FAIL int_after_exc got gap=%0d ack=%b id=%h want gap=4 ack=1 id=22",
               gap, ack_valid_o, ack_interrupt_id_o);
    end
    interrupt_req_i = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic test_halt_resume();
    dbg_haltreq_i     = 1'b1;
    exception_valid_i = 1'b1;
    step();
    total++;
    if ({zpc_pc_ctrl_o, debug_mode_valid_o, trap_valid_o} !== 5'b100_1_0) begin
      bad++;
      $display("FAIL halt_over_exc got code=%b dbg=%b trap=%b want code=100 dbg=1 trap=0",
               zpc_pc_ctrl_o, debug_mode_valid_o, trap_valid_o);
    end
    dbg_haltreq_i = 1'b0;
    step();
    step();
    total++;
    if ({zpc_pc_ctrl_o, debug_mode_valid_o, trap_valid_o} !== 5'b100_1_0) begin
      bad++;
      $display("FAIL halt_held got code=%b dbg=%b trap=%b want code=100 dbg=1 trap=0",
               zpc_pc_ctrl_o, debug_mode_valid_o, trap_valid_o);
    end
    exception_valid_i = 1'b0;
    dbg_haltreq_i     = 1'b1;
    dbg_resumereq_i   = 1'b1;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b100 || resumeack_o !== 1'b0) begin
      bad++;
      $display("FAIL halt_plus_resume got code=%b rack=%b want code=100 rack=0", zpc_pc_ctrl_o, resumeack_o);
    end
    dbg_haltreq_i = 1'b0;
    step();
    total++;
    if ({zpc_pc_ctrl_o, resumeack_o, debug_mode_valid_o} !== 5'b101_1_0) begin
      bad++;
      $display("FAIL resume got code=%b rack=%b dbg=%b want code=101 rack=1 dbg=0",
               zpc_pc_ctrl_o, resumeack_o, debug_mode_valid_o);
    end
    dbg_resumereq_i = 1'b0;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b001 || resumeack_o !== 1'b0) begin
      bad++;
      $display("FAIL resume_to_run got code=%b rack=%b want code=001 rack=0", zpc_pc_ctrl_o, resumeack_o);
    end
  endtask

  task automatic test_mret_wdt();
    stall_valid_i = 1'b1;
    mret_valid_i  = 1'b1;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b001) begin
      bad++;
      $display("FAIL mret_stalled got=%b want=001", zpc_pc_ctrl_o);
    end
    mret_valid_i  = 1'b0;
    stall_valid_i = 1'b0;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b001) begin
      bad++;
      $display("FAIL mret_dropped got=%b want=001", zpc_pc_ctrl_o);
    end
    mret_valid_i = 1'b1;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b011) begin
      bad++;
      $display("FAIL mret_exit got=%b want=011", zpc_pc_ctrl_o);
    end
    mret_valid_i = 1'b0;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b001) begin
      bad++;
      $display("FAIL mret_one_cycle got=%b want=001", zpc_pc_ctrl_o);
    end
    dbg_haltreq_i = 1'b1;
    step();
    wdt_reset_i = 1'b1;
    step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b000 || debug_mode_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL wdt_in_halt got code=%b dbg=%b want code=000 dbg=0", zpc_pc_ctrl_o, debug_mode_valid_o);
    end
    wdt_reset_i   = 1'b0;
    dbg_haltreq_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    total++;
    if (zpc_pc_ctrl_o !== 3'b001) begin
      bad++;
      $display("FAIL wdt_reboot got=%b want=001", zpc_pc_ctrl_o);
    end
  endtask

`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
  task automatic test_step();
    logic [2:0] seq [3];
    dbg_haltreq_i = 1'b1;
    step();
    dbg_haltreq_i   = 1'b0;
    dbg_resumereq_i = 1'b1;
    dbg_step_i      = 1'b1;
    step();
    seq[0] = zpc_pc_ctrl_o;
    dbg_resumereq_i = 1'b0;
    step();
    seq[1] = zpc_pc_ctrl_o;
    exception_valid_i = 1'b1;
    step();
    seq[2] = zpc_pc_ctrl_o;
    total++;
    if (seq[0] !== 3'b101 || seq[1] !== 3'b001 || seq[2] !== 3'b100 || trap_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL step_seq got=%b,%b,%b trap=%b want=101,001,100 trap=0", seq[0], seq[1], seq[2], trap_valid_o);
    end
    exception_valid_i = 1'b0;
    dbg_step_i        = 1'b0;
  endtask
`endif

  initial begin
    z_rst = 1'b1; wdt_reset_i = 1'b0; dbg_hartreset_i = 1'b0; stall_valid_i = 1'b0;
    exception_valid_i = 1'b0; interrupt_req_i = 1'b0; interrupt_id_i = 8'h00;
    csr_mstatus_mie_i = 1'b0; mret_valid_i = 1'b0; dbg_haltreq_i = 1'b0; dbg_resumereq_i = 1'b0;
`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
    dbg_step_i = 1'b0;
`endif
    test_reset();
    test_interrupt();
    test_exc_vs_int();
    test_halt_resume();
    test_mret_wdt();
`ifdef ZILLA_PC_CTRL_DBG_STEP_EN
    test_step();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
